// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pkg
//  Purpose  : Shared constants and state encoding for the MAC sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

  // Default upper bound on terms per job and width of the term count/index.
  localparam int c_MAX_TERMS = 10;
  localparam int c_CNT_W     = 4;

  // Controller states, one per phase of a dot-product job.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_OP = 3'd1,
    S_LOAD_AB = 3'd2,
    S_MAC     = 3'd3,
    S_OUT     = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_term_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mac_term_counter
//  Purpose  : Loadable term counter. An up-counter supplies the 0-based term
//             index while a down-counter of remaining terms yields the
//             last-term flag without a subtract-and-compare on the index.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_term_counter
  import mac_pkg::*;
#(
  parameter int CNT_W = c_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_last
);

  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_remain;

  // Load clears the index and arms the remaining-term count; increments
  // stop at the last term so the index can never run past the job length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx    <= '0;
      r_remain <= '0;
    end else if (i_load) begin
      r_idx    <= '0;
      r_remain <= i_count - CNT_W'(1);
    end else if (i_inc && (r_remain != '0)) begin
      r_idx    <= r_idx + CNT_W'(1);
      r_remain <= r_remain - CNT_W'(1);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_remain == '0);

endmodule : mac_term_counter
`default_nettype wire

// File: rtl/mac_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mac_controller
//  Purpose  : Sequences a 4-bit multiply-accumulate datapath through an
//             N-term dot product. Operand pairs arrive over valid/ready;
//             the controller issues one-hot load strobes, the term counter
//             enable and a busy/done job status. All outputs are registered
//             and decoded from the next state.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_controller
  import mac_pkg::*;
#(
  parameter int MAX_TERMS = c_MAX_TERMS,
  parameter int CNT_W     = c_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_a,
  output logic             load_b,
  output logic             load_m,
  output logic             load_acc,
  output logic             load_out,
  output logic             count_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] term_idx
);

  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_TERMS);

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] w_n_clamped;
  logic [CNT_W-1:0] w_idx;
  logic             w_last;
  logic             w_load_cnt;
  logic             w_inc;

  logic             w_in_ready;
  logic             w_load_ab;
  logic             w_load_m;
  logic             w_load_acc;
  logic             w_load_out;
  logic             w_cnt_en;
  logic             w_busy;
  logic             w_done;

  logic             r_in_ready;
  logic             r_load_ab;
  logic             r_load_m;
  logic             r_load_acc;
  logic             r_load_out;
  logic             r_cnt_en;
  logic             r_busy;
  logic             r_done;

  // Requested term count limited to the supported maximum.
  always_comb begin
    w_n_clamped = (n_terms > c_MAX_CNT) ? c_MAX_CNT : n_terms;
  end

  mac_term_counter #(
    .CNT_W   (CNT_W)
  ) u_term_counter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_cnt),
    .i_count (w_n_clamped),
    .i_inc   (w_inc),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  // Next-state logic plus output decode from the next state. The index is
  // unchanged between LOAD_AB and MAC, so the current index selects
  // load_m (first term) versus load_acc for the upcoming MAC cycle.
  always_comb begin
    w_next     = r_state;
    w_load_cnt = 1'b0;
    w_inc      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && (n_terms != '0)) begin
          w_next     = S_WAIT_OP;
          w_load_cnt = 1'b1;
        end
      end
      S_WAIT_OP: begin
        if (in_valid) begin
          w_next = S_LOAD_AB;
        end
      end
      S_LOAD_AB: begin
        w_next = S_MAC;
      end
      S_MAC: begin
        if (w_last) begin
          w_next = S_OUT;
        end else begin
          w_next = S_WAIT_OP;
          w_inc  = 1'b1;
        end
      end
      S_OUT: begin
        w_next = S_FINISH;
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    w_in_ready = (w_next == S_WAIT_OP);
    w_load_ab  = (w_next == S_LOAD_AB);
    w_load_m   = (w_next == S_MAC) && (w_idx == '0);
    w_load_acc = (w_next == S_MAC) && (w_idx != '0);
    w_load_out = (w_next == S_OUT);
    w_cnt_en   = (w_next == S_MAC);
    w_busy     = (w_next == S_WAIT_OP) || (w_next == S_LOAD_AB) ||
                 (w_next == S_MAC)     || (w_next == S_OUT);
    w_done     = (w_next == S_FINISH);
  end

  // State register and registered outputs; reset abandons any job at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_load_ab  <= 1'b0;
      r_load_m   <= 1'b0;
      r_load_acc <= 1'b0;
      r_load_out <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_in_ready;
      r_load_ab  <= w_load_ab;
      r_load_m   <= w_load_m;
      r_load_acc <= w_load_acc;
      r_load_out <= w_load_out;
      r_cnt_en   <= w_cnt_en;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign in_ready     = r_in_ready;
  assign load_a       = r_load_ab;
  assign load_b       = r_load_ab;
  assign load_m       = r_load_m;
  assign load_acc     = r_load_acc;
  assign load_out     = r_load_out;
  assign count_enable = r_cnt_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign term_idx     = w_idx;

endmodule : mac_controller
`default_nettype wire

// File: tb/tb_mac_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_controller
//  Purpose  : Randomized scoreboard bench for mac_controller with a
//             behavioural datapath and a job-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_controller;

  localparam int MAXT = 10;
  localparam int CW   = 4;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          start    = 1'b0;
  logic [CW-1:0] n_terms  = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          load_a, load_b, load_m, load_acc, load_out;
  logic          count_enable, busy, done;
  logic [CW-1:0] term_idx;

  // Operand bus seen by the datapath model.
  logic [3:0]    in_a = '0;
  logic [3:0]    in_b = '0;
  logic [3:0]    dp_a, dp_b;
  logic [15:0]   dp_acc, dp_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int n;
    int sum;
    int lat;
  } job_t;

  job_t exp_q[$];
  job_t mon_j;

  int g_a[16];
  int g_b[16];
  int g_stall[17];

  mac_controller #(
    .MAX_TERMS    (MAXT),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_terms      (n_terms),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load_a       (load_a),
    .load_b       (load_b),
    .load_m       (load_m),
    .load_acc     (load_acc),
    .load_out     (load_out),
    .count_enable (count_enable),
    .busy         (busy),
    .done         (done),
    .term_idx     (term_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural datapath driven by the controller's strobes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_a   <= '0;
      dp_b   <= '0;
      dp_acc <= '0;
      dp_out <= '0;
    end else begin
      if (load_a)   dp_a   <= in_a;
      if (load_b)   dp_b   <= in_b;
      if (load_m)   dp_acc <= 16'(dp_a) * 16'(dp_b);
      if (load_acc) dp_acc <= dp_acc + 16'(dp_a) * 16'(dp_b);
      if (load_out) dp_out <= dp_acc;
    end
  end

  // Monitor: per-cycle protocol checks and job completion scoreboard.
  int mac_cnt   = 0;
  int cyc       = 0;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      mac_cnt   = 0;
      cyc       = 0;
      prev_busy = 1'b0;
    end else begin
      chk("strobe_exclusive",
          int'((int'(load_a | load_b) + int'(load_m) + int'(load_acc) + int'(load_out)) <= 1
               && load_a == load_b), 1);
      chk("term_idx_range", int'(term_idx <= CW'(MAXT - 1)), 1);
      chk("count_enable_with_mac", int'(count_enable), int'(load_m | load_acc));
      if (in_ready) begin
        chk("quiet_while_ready",
            int'(load_a) + int'(load_m) + int'(load_acc) + int'(load_out) + int'(done), 0);
        chk("busy_while_ready", int'(busy), 1);
      end
      if (load_m || load_acc) begin
        chk("mac_term_idx", int'(term_idx), mac_cnt);
        chk("mac_first_is_load_m", int'(load_m), int'(mac_cnt == 0));
        mac_cnt++;
      end
      if (busy && !prev_busy) cyc = 1;
      else if (cyc != 0)      cyc++;
      if (done) begin
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_j = exp_q.pop_front();
          chk("job_mac_count", mac_cnt, mon_j.n);
          chk("job_result", int'(dp_out), mon_j.sum);
          chk("job_latency", cyc, mon_j.lat);
          chk("busy_low_at_done", int'(busy), 0);
        end
        mac_cnt = 0;
        cyc     = 0;
      end
      prev_busy = busy;
    end
  end

  // Runs one job from the g_* tables. abort_at >= 0 resets the DUT right
  // after that term's operand transfer and drops the job.
  task automatic run_job(input int n_req, input int abort_at);
    int n_eff  = (n_req > MAXT) ? MAXT : n_req;
    int sum    = 0;
    int stalls = 0;
    int t      = 0;
    int wcnt   = 0;
    int k      = 0;
    int left;
    @(negedge clk);
    start    = 1'b1;
    n_terms  = CW'(n_req);
    in_valid = 1'b0;
    @(negedge clk);
    left = g_stall[0];
    while (t < n_eff) begin
      start   = ($urandom_range(0, 3) == 0);
      n_terms = CW'($urandom);
      if (in_ready) begin
        wcnt = 0;
        if (left > 0) begin
          in_valid = 1'b0;
          left--;
          stalls++;
        end else begin
          in_valid = 1'b1;
          in_a     = 4'(g_a[t]);
          in_b     = 4'(g_b[t]);
          sum     += g_a[t] * g_b[t];
          t++;
          left     = g_stall[t];
          if (t - 1 == abort_at) begin
            @(negedge clk);
            #2 rst = 1'b0;
            #1 chk("async_reset_outputs",
                   int'({in_ready, load_a, load_b, load_m, load_acc, load_out,
                         count_enable, busy, done}), 0);
            chk("async_reset_term_idx", int'(term_idx), 0);
            start    = 1'b0;
            in_valid = 1'b0;
            repeat (3) begin
              @(negedge clk);
              chk("reset_no_done_busy", int'(done) + int'(busy), 0);
            end
            #2 rst = 1'b1;
            return;
          end
        end
      end else begin
        in_valid = 1'($urandom);
        wcnt++;
        if (wcnt > 20) begin
          chk("in_ready_timeout", wcnt, 0);
          start    = 1'b0;
          in_valid = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    exp_q.push_back('{n_eff, sum, 3 * n_eff + 2 + stalls});
    while (!done && k < 20) begin
      start    = ($urandom_range(0, 3) == 0);
      n_terms  = CW'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", k, 0);
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_random(input int max_stall);
    for (int i = 0; i < 16; i++) begin
      g_a[i]     = $urandom_range(0, 15);
      g_b[i]     = $urandom_range(0, 15);
      g_stall[i] = $urandom_range(0, max_stall);
    end
    g_stall[16] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("reset_outputs",
        int'({in_ready, load_a, load_b, load_m, load_acc, load_out,
              count_enable, busy, done}), 0);
    chk("reset_term_idx", int'(term_idx), 0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Single term, in_valid held high
    fill_random(0);
    run_job(1, -1);

    // Three-term example on the datapath model
    fill_random(0);
    g_a[0] = 2;  g_b[0] = 3;
    g_a[1] = 4;  g_b[1] = 5;
    g_a[2] = 15; g_b[2] = 15;
    run_job(3, -1);
    chk("example_out_251", int'(dp_out), 251);
    chk("busy_after_example", int'(busy), 0);

    // Stall of 4 cycles before the second pair
    fill_random(0);
    g_stall[1] = 4;
    run_job(2, -1);

    // Clamp to maximum
    fill_random(0);
    run_job(15, -1);

    // start with zero terms is ignored
    @(negedge clk);
    start   = 1'b1;
    n_terms = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      chk("zero_terms_ignored", int'(busy) + int'(in_ready), 0);
      @(negedge clk);
    end

    // Reset during the third term, then a normal job
    fill_random(1);
    run_job(5, 2);
    fill_random(1);
    run_job(4, -1);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      fill_random(3);
      run_job($urandom_range(1, 15), -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mac_controller
`default_nettype wire
